muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E stage and runs multi-cycle operations.
- Drives busy into the hazard unit, which converts it into StallF/StallD/FlushE so dependent instructions (MFHI/MFLO, next muldiv op) wait.
- HI/LO outputs feed the E-stage result mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width.
MUL_CYCLES, 4, busy cycles for MULT/MULTU (min 1).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low; clears all state.
startE  input  1  valid muldiv op in E this cycle (already masked by FlushE).
mdopE  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (no-op).
srcaE  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
srcbE  input  WIDTH  rt operand (divisor / multiplier).
abort  input  1  cancel in-flight op (exception/redirect).
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  multi-cycle op in progress.
done  output  1  one-cycle pulse on the edge HI/LO take a MUL/DIV result.

Behaviour:
- Reset (reset=0, async): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the op.
- States: IDLE, MUL, DIV, FIX (divide sign correction).
- IDLE, startE=1:
  - MTHI/MTLO: write hi/lo at that edge, stay IDLE, busy stays 0.
  - MULT/MULTU: latch operands, go MUL, counter=MUL_CYCLES-1.
  - DIV/DIVU, srcbE!=0: latch |operands| (signed) or raw (unsigned) and signs, go DIV, counter=WIDTH-1.
  - DIV/DIVU, srcbE==0: no state entry. Next edge lo=all-ones, hi=srcaE, done=1, busy never asserts.
  - mdopE none/reserved: no effect.
- startE while busy=1 is ignored. The hazard unit stalls, so the op is re-presented after busy falls.
- MUL: counter decrements each cycle. On the edge leaving counter==0: {hi,lo} = full 2*WIDTH product (signed for MULT, unsigned for MULTU), done=1, go IDLE. busy is high exactly MUL_CYCLES cycles.
- DIV: radix-2 restoring, one quotient bit per cycle for WIDTH cycles, then FIX for 1 cycle. busy is high WIDTH+1 cycles.
- FIX: apply signs and write lo=quotient, hi=remainder, done=1, go IDLE.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1: lo=0x80000000, hi=0.
- busy = (state != IDLE), registered. It falls on the same edge hi/lo update, so a stalled MFHI in E sees the new value the following cycle.
- abort=1 in MUL/DIV/FIX: go IDLE next edge, hi/lo unchanged, no done. abort in IDLE: no effect. abort and startE in the same IDLE cycle: abort wins, op dropped.
- Back-to-back: a new start is accepted in the cycle busy is 0, including the cycle right after done.

Test Plan:
- MULT 0xFFFFFFFE(-2) x 3 -> busy high 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7 / 2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5 / 0 -> next edge lo=0xFFFFFFFF, hi=5, busy stays 0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never rises; MTHI during DIV busy -> ignored, hi unchanged.
- Start DIV, abort on busy cycle 10 -> busy low next cycle, hi/lo retain prior values, no done; new MULT next cycle accepted.
- Assert reset low mid-MUL (cycle 2) -> hi=lo=0, busy=0 immediately without a clock edge; after release, MULT 6 x 7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Multiplies take MUL_CYCLES cycles; divides are radix-2 restoring plus one sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       mdopE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier, or divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             done_q, done_d;

  // Sign-extend to 2*WIDTH so the low 2*WIDTH product bits are exact for both signednesses.
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  assign mul_a   = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
  assign mul_b   = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
  assign product = mul_a * mul_b;

  logic [WIDTH:0] div_shift, div_diff;
  assign div_shift = {rem_q, opa_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startE && !abort) begin
          case (mdopE)
            OP_MTHI: hi_d = srcaE;
            OP_MTLO: lo_d = srcaE;
            OP_MULT, OP_MULTU: begin
              opa_d   = srcaE;
              opb_d   = srcbE;
              sgn_d   = (mdopE == OP_MULT);
              cnt_d   = CW'(MUL_CYCLES - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (srcbE == '0) begin
                lo_d   = '1;
                hi_d   = srcaE;
                done_d = 1'b1;
              end else begin
                sgn_d   = (mdopE == OP_DIV);
                negq_d  = (mdopE == OP_DIV) && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                negr_d  = (mdopE == OP_DIV) && srcaE[WIDTH-1];
                opa_d   = ((mdopE == OP_DIV) && srcaE[WIDTH-1]) ? -srcaE : srcaE;
                opb_d   = ((mdopE == OP_DIV) && srcbE[WIDTH-1]) ? -srcbE : srcbE;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          lo_d    = negq_q ? -opa_q : opa_q;
          hi_d    = negr_q ? -rem_q : rem_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
